// File: rtl/pg_serial_adder_pkg.sv
// Shared definitions for the digit-serial PG adder: FSM state encoding and
// the number of operand bits resolved per clock.
package pg_serial_adder_pkg;

    // Controller states; encodings are fixed so debug probes decode consistently.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operand bits consumed per RUN cycle.
    localparam int SLICE_W = 2;

endpackage : pg_serial_adder_pkg

// File: rtl/pg_serial_adder_carry_slice_2bits.sv
// Combinational 2-bit slice: forms propagate/generate for each bit and
// resolves both slice carries with lookahead equations rather than a ripple.
module carry_slice_2bits (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       c,
    output logic [1:0] s,
    output logic       c1,
    output logic       c2
);

    logic w_p0, w_g0, w_p1, w_g1;

    // Per-bit propagate/generate, then lookahead carries and sum bits.
    always_comb begin
        w_p0 = a[0] ^ b[0];
        w_g0 = a[0] & b[0];
        w_p1 = a[1] ^ b[1];
        w_g1 = a[1] & b[1];
        c1   = w_g0 | (w_p0 & c);
        c2   = w_g1 | (w_p1 & w_g0) | (w_p1 & w_p0 & c);
        s[0] = w_p0 ^ c;
        s[1] = w_p1 ^ c1;
    end

endmodule : carry_slice_2bits

// File: rtl/pg_serial_adder.sv
// Digit-serial adder/subtractor. Operands are latched on an in_valid/in_ready
// handshake, consumed two bits per cycle through a lookahead slice, and the
// result is presented on an out_valid/out_ready handshake.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high; the producer holds its data stable while
// valid is high and ready is low. in_ready is high only in IDLE, so operands
// offered while RUN/DONE are neither captured nor queued.
module pg_serial_adder
    import pg_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    // The accumulator only needs the slices produced before the final one;
    // the final slice is merged straight into the captured result.
    localparam int ACC_W  = (WIDTH > SLICE_W) ? (WIDTH - SLICE_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_areg;
    logic [WIDTH-1:0]   r_breg;
    logic               r_creg;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic [1:0]         w_s;
    logic               w_c1;
    logic               w_c2;
    logic [WIDTH-1:0]   w_result;
    logic [ACC_W-1:0]   w_acc_next;

    carry_slice_2bits u_slice (
        .a  (r_areg[1:0]),
        .b  (r_breg[1:0]),
        .c  (r_creg),
        .s  (w_s),
        .c1 (w_c1),
        .c2 (w_c2)
    );

    // Newest slice enters at the top; after the last slice the full result
    // is {last slice, accumulated earlier slices}.
    if (WIDTH > SLICE_W) begin : g_wide
        assign w_result   = {w_s, r_acc};
        assign w_acc_next = w_result[WIDTH-1:SLICE_W];
    end else begin : g_single
        assign w_result   = w_s;
        assign w_acc_next = '0;
    end

    // Controller, operand shifters, carry/counter and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_areg      <= '0;
            r_breg      <= '0;
            r_creg      <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_areg     <= a;
                        r_breg     <= sub ? ~b : b;
                        r_creg     <= sub ? 1'b1 : cin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_areg <= r_areg >> SLICE_W;
                    r_breg <= r_breg >> SLICE_W;
                    r_acc  <= w_acc_next;
                    r_creg <= w_c2;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        // c1 of the last slice is the carry into the MSB.
                        r_sum       <= w_result;
                        r_cout      <= w_c2;
                        r_ovf       <= w_c1 ^ w_c2;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign busy      = r_busy;

endmodule : pg_serial_adder
